mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit between the execute stage and the word-wide synchronous data RAM (32-bit, word-addressed, single write enable, 1-cycle registered read).
- Converts RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word accesses.
- Sub-word stores run as a read-modify-write sequence because the RAM has no byte enables.
- Extracts and sign- or zero-extends load data, and flags misaligned or illegal accesses.

Parameters:
- ADDRESS_WIDTH, 14, RAM word-address width; the byte address uses bits [ADDRESS_WIDTH+1:2].
- DATA_WIDTH, 32, RAM word width; fixed at 32, other values are unsupported.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- reqValid  input  1  request present.
- reqReady  output  1  high only in IDLE; a request is accepted when reqValid && reqReady.
- reqWrite  input  1  1 = store, 0 = load.
- reqFunct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- reqAddr  input  32  byte address; bits above ADDRESS_WIDTH+1 are ignored.
- reqWData  input  32  store data; the low byte/half is used for SB/SH.
- done  output  1  one-cycle completion pulse.
- loadData  output  32  extended load result; valid when done && !fault && the access was a load.
- fault  output  1  pulses with done for a misaligned or illegal access.
- ramWEn  output  1  RAM write enable.
- ramAddr  output  ADDRESS_WIDTH  RAM word address.
- ramDataIn  output  32  RAM write data.
- ramDataOut  input  32  RAM read data, valid one cycle after the address is presented.

Behaviour:
- States: IDLE, LOAD_WAIT, RMW_MERGE.
- Reset values: state=IDLE, done=0, fault=0, loadData=0, latched address/op/data=0.
- ramWEn is forced 0 combinationally while reset is high, so a write in progress is aborted.
- Lane selection: little-endian; byte k = bits [8k+7:8k], k = addr[1:0]; half h = bits [16h+15:16h], h = addr[1].
- Legality:
  - Illegal funct3: 011, 110, 111, or any 1xx with reqWrite=1.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
- Fault path:
  - Accepted in cycle T: no RAM write; ramWEn=0.
  - T+1: done=1, fault=1, loadData unchanged. State stays IDLE, so reqReady stays high.
- Load:
  - T: ramAddr=reqAddr[ADDRESS_WIDTH+1:2], ramWEn=0. Latch funct3 and addr[1:0]. Go to LOAD_WAIT.
  - T+1: sample ramDataOut, extract the selected lane, sign-extend (B/H) or zero-extend (BU/HU). Register the result into loadData. Go to IDLE.
  - T+2: done=1, loadData valid, reqReady=1.
- SW:
  - T: ramWEn=1, ramAddr=word address, ramDataIn=reqWData. State stays IDLE.
  - T+1: done=1.
- SB/SH:
  - T: read the word address. Latch the address, lane and store data. Go to RMW_MERGE.
  - T+1: ramAddr=latched address; ramDataIn=ramDataOut with the selected lane replaced; ramWEn=1. Go to IDLE.
  - T+2: done=1.
- Back-to-back:
  - A new request may be accepted in the same cycle done pulses for the previous one, whenever the state is IDLE.
  - Back-to-back SW sustains one store per cycle.
- In IDLE with no request: ramWEn=0; ramAddr tracks reqAddr[ADDRESS_WIDTH+1:2] (don't-care); ramDataIn=reqWData.
- done and fault are never high for more than one cycle per request.
- Reset asserted during LOAD_WAIT or RMW_MERGE: return to IDLE next cycle; no done pulse and no RAM write for the interrupted request.
- Address wrap: word address is truncated to ADDRESS_WIDTH bits, with no fault.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_CHECK_EN.
- Defined:
  - Misaligned H/HU/SH/W/SW accesses fault as specified.
  - Illegal funct3 also faults.
- Undefined:
  - No misalignment faults. Halfword accesses force addr[0]=0; word accesses force addr[1:0]=0; the access then proceeds normally.
  - Illegal funct3 still faults.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> ramWEn=1 at T with ramAddr=4; the load's done at T+2 with loadData=0xDEADBEEF, fault=0.
- Word@0x10=0xDEADBEEF; SB 0x55 @0x11; LW @0x10 -> RAM write at T+1 of 0xDEAD55EF; done at T+2; LW returns 0xDEAD55EF.
- Word@0x20=0x80F0017F; LB @0x20 -> 0x0000007F; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80F0; LHU @0x22 -> 0x000080F0.
- With macro defined: LW @0x12 and SH @0x13 -> done=fault=1 at T+1, ramWEn never high, loadData unchanged.
- Without macro: SH 0x1234 @0x13 -> behaves as SH @0x12, upper half replaced.
- Reset asserted in the RMW_MERGE cycle of SB @0x30 -> ramWEn stays 0, word@0x30 unchanged, no done; reqReady=1 the cycle after reset deasserts.
- Three back-to-back SW at 0x0, 0x4, 0x8 -> accepted on consecutive cycles, three consecutive done pulses.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the execute stage and a word-wide
// synchronous data RAM (1-cycle registered read, single write enable, no byte
// enables). Sub-word stores run as read-modify-write; loads are lane-extracted
// and sign/zero-extended.
//
// Optional feature macro: MEM_ACCESS_MISALIGN_CHECK_EN
//   defined   : misaligned H/HU/SH/W/SW accesses complete with a fault.
//   undefined : misaligned low address bits are cleared and the access
//               proceeds normally. Illegal funct3 faults in both builds.
module mem_access_unit #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic                     reqWrite,
    input  logic [2:0]               reqFunct3,
    input  logic [31:0]              reqAddr,
    input  logic [31:0]              reqWData,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    loadData,
    output logic                     fault,
    output logic                     ramWEn,
    output logic [ADDRESS_WIDTH-1:0] ramAddr,
    output logic [DATA_WIDTH-1:0]    ramDataIn,
    input  logic [DATA_WIDTH-1:0]    ramDataOut
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_RMW_MERGE = 2'd2;

    // Select the addressed lane of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of a RAM word with the store data.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane,
                                            input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        if (f3[1:0] == 2'b01) begin
            if (lane[1]) begin
                res[31:16] = wdata[15:0];
            end else begin
                res[15:0] = wdata[15:0];
            end
        end else begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                2'd3:    res[31:24] = wdata[7:0];
                default: res[7:0]   = wdata[7:0];
            endcase
        end
        return res;
    endfunction

    logic [1:0]               r_state;
    logic                     r_done;
    logic                     r_fault;
    logic [DATA_WIDTH-1:0]    r_load_data;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [1:0]               r_lane;
    logic [2:0]               r_funct3;
    logic [31:0]              r_wdata;

    logic                     w_accept;
    logic                     w_illegal;
    logic                     w_misaligned;
    logic                     w_is_half;
    logic                     w_is_word;
    logic [1:0]               w_lane;
    logic                     w_fault_req;
    logic                     w_wen;
    logic [ADDRESS_WIDTH-1:0] w_word_addr;
    logic                     w_unused_addr;

    // Byte-address bits above the RAM range wrap silently.
    assign w_unused_addr = &{1'b0, reqAddr[31:ADDRESS_WIDTH+2]};
    assign w_word_addr   = reqAddr[ADDRESS_WIDTH+1:2];
    assign w_accept      = reqValid && (r_state == ST_IDLE);
    assign w_is_half     = (reqFunct3[1:0] == 2'b01);
    assign w_is_word     = (reqFunct3 == 3'b010);
    assign w_illegal     = (reqFunct3 == 3'b011) || (reqFunct3 == 3'b110) ||
                           (reqFunct3 == 3'b111) || (reqFunct3[2] && reqWrite);
    assign w_fault_req   = w_illegal || w_misaligned;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign w_misaligned = (w_is_half && reqAddr[0]) ||
                          (w_is_word && (reqAddr[1:0] != 2'b00));
    assign w_lane       = reqAddr[1:0];
`else
    // Misaligned offsets are rounded down to the natural boundary instead.
    assign w_misaligned = 1'b0;
    assign w_lane       = w_is_word ? 2'b00 :
                          (w_is_half ? {reqAddr[1], 1'b0} : reqAddr[1:0]);
`endif

    assign reqReady = (r_state == ST_IDLE);
    assign done     = r_done;
    assign fault    = r_fault;
    assign loadData = r_load_data;

    // RAM port drive: SW writes directly in IDLE, RMW_MERGE writes the merged word.
    always_comb begin
        w_wen     = 1'b0;
        ramAddr   = w_word_addr;
        ramDataIn = reqWData;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_fault_req && reqWrite && w_is_word) begin
                    w_wen = 1'b1;
                end else begin
                    w_wen = 1'b0;
                end
            end
            ST_LOAD_WAIT: begin
                ramAddr = r_addr;
            end
            ST_RMW_MERGE: begin
                ramAddr   = r_addr;
                ramDataIn = f_merge(ramDataOut, r_funct3, r_lane, r_wdata);
                w_wen     = 1'b1;
            end
            default: begin
                w_wen = 1'b0;
            end
        endcase
        // A reset cycle must never commit a write, even mid-RMW.
        if (reset) begin
            ramWEn = 1'b0;
        end else begin
            ramWEn = w_wen;
        end
    end

    // Sequencer state, latched request and registered completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_load_data <= '0;
            r_addr      <= '0;
            r_lane      <= 2'd0;
            r_funct3    <= 3'd0;
            r_wdata     <= 32'd0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_fault_req) begin
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else if (reqWrite && w_is_word) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr   <= w_word_addr;
                            r_lane   <= w_lane;
                            r_funct3 <= reqFunct3;
                            r_wdata  <= reqWData;
                            r_state  <= reqWrite ? ST_RMW_MERGE : ST_LOAD_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD_WAIT: begin
                    r_load_data <= f_extract(ramDataOut, r_funct3, r_lane);
                    r_done      <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_RMW_MERGE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1-cycle-read RAM.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        done;
    logic [31:0] loadData;
    logic        fault;
    logic        ramWEn;
    logic [13:0] ramAddr;
    logic [31:0] ramDataIn;
    logic [31:0] ramDataOut;

    logic [31:0] mem [0:16383];

    int          total;
    int          bad;
    logic [31:0] last_ld;
    logic [31:0] w10_exp;

    mem_access_unit #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .reqFunct3 (reqFunct3),
        .reqAddr   (reqAddr),
        .reqWData  (reqWData),
        .done      (done),
        .loadData  (loadData),
        .fault     (fault),
        .ramWEn    (ramWEn),
        .ramAddr   (ramAddr),
        .ramDataIn (ramDataIn),
        .ramDataOut(ramDataOut)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write-enable commit and registered read.
    always @(posedge clk) begin
        if (ramWEn) mem[ramAddr] <= ramDataIn;
        ramDataOut <= mem[ramAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        reqValid  = 1'b1;
        reqWrite  = wr;
        reqFunct3 = f3;
        reqAddr   = a;
        reqWData  = d;
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, f3, a, 32'd0);
        chk({tag, "_wen_t"}, 32'(ramWEn), 32'd0);
        step();
        chk({tag, "_done_t1"}, 32'(done), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_data"}, loadData, exp);
        last_ld = exp;
    endtask

    task automatic do_sw(input string tag, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_waddr);
        drive(1'b1, 3'b010, a, d);
        chk({tag, "_wen"}, 32'(ramWEn), 32'd1);
        chk({tag, "_addr"}, 32'(ramAddr), exp_waddr);
        chk({tag, "_din"}, ramDataIn, d);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic do_sub(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_word);
        drive(1'b1, f3, a, d);
        chk({tag, "_wen_t"}, 32'(ramWEn), 32'd0);
        step();
        chk({tag, "_wen_t1"}, 32'(ramWEn), 32'd1);
        chk({tag, "_merge"}, ramDataIn, exp_word);
        chk({tag, "_done_t1"}, 32'(done), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic do_fault(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
        drive(wr, f3, a, 32'h0000_1234);
        chk({tag, "_wen_t"}, 32'(ramWEn), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_fault"}, 32'(fault), 32'd1);
        chk({tag, "_ld_keep"}, loadData, last_ld);
        chk({tag, "_ready"}, 32'(reqReady), 32'd1);
        chk({tag, "_wen_t1"}, 32'(ramWEn), 32'd0);
        step();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_fault_clr"}, 32'(fault), 32'd0);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0;
        reqFunct3 = 3'd0; reqAddr = 32'd0; reqWData = 32'd0;
        total = 0; bad = 0; last_ld = 32'd0; w10_exp = 32'd0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;

        // Reset: a store presented during reset must not reach the RAM.
        drive(1'b1, 3'b010, 32'h40, 32'hFFFF_FFFF);
        chk("rst_wen", 32'(ramWEn), 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_ld", loadData, 32'd0);
        chk("rst_ready", 32'(reqReady), 32'd1);
        chk("rst_mem40", mem[16], 32'd0);

        // SW then LW, load issued in the same cycle the store's done pulses.
        do_sw("sw10", 32'h10, 32'hDEAD_BEEF, 32'd4);
        drive(1'b0, 3'b010, 32'h10, 32'd0);
        chk("lw10_ready", 32'(reqReady), 32'd1);
        step();
        chk("lw10_busy", 32'(reqReady), 32'd0);
        step();
        chk("lw10_done", 32'(done), 32'd1);
        chk("lw10_data", loadData, 32'hDEAD_BEEF);
        chk("lw10_fault", 32'(fault), 32'd0);
        last_ld = 32'hDEAD_BEEF;

        // SB read-modify-write; only the low byte of the store data is used.
        do_sub("sb11", 3'b000, 32'h11, 32'hAAAA_AA55, 32'hDEAD_55EF);
        do_load("lw10b", 3'b010, 32'h10, 32'hDEAD_55EF);

        // Lane extraction and extension.
        do_sw("sw20", 32'h20, 32'h80F0_017F, 32'd8);
        do_load("lb20", 3'b000, 32'h20, 32'h0000_007F);
        do_load("lb23", 3'b000, 32'h23, 32'hFFFF_FF80);
        do_load("lbu23", 3'b100, 32'h23, 32'h0000_0080);
        do_load("lh22", 3'b001, 32'h22, 32'hFFFF_80F0);
        do_load("lhu22", 3'b101, 32'h22, 32'h0000_80F0);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        do_fault("lw12_mis", 1'b0, 3'b010, 32'h12);
        do_fault("sh13_mis", 1'b1, 3'b001, 32'h13);
        w10_exp = 32'hDEAD_55EF;
        do_load("lw10_keep", 3'b010, 32'h10, w10_exp);
`else
        do_sub("sh13", 3'b001, 32'h13, 32'h0000_1234, 32'h1234_55EF);
        w10_exp = 32'h1234_55EF;
        do_load("lw12_align", 3'b010, 32'h12, w10_exp);
        do_load("lhu13_align", 3'b101, 32'h13, 32'h0000_1234);
`endif

        // Illegal funct3 faults regardless of build.
        do_fault("ill_011", 1'b0, 3'b011, 32'h20);
        do_fault("ill_sbu", 1'b1, 3'b100, 32'h20);
        do_fault("ill_111", 1'b0, 3'b111, 32'h20);
        chk("ill_mem20", mem[8], 32'h80F0_017F);

        // Reset during the RMW_MERGE cycle aborts the write and the done pulse.
        do_sw("sw30", 32'h30, 32'h1122_3344, 32'd12);
        drive(1'b1, 3'b000, 32'h30, 32'h0000_00AB);
        step();
        reset = 1'b1;
        #1;
        chk("rmwrst_wen", 32'(ramWEn), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rmwrst_done", 32'(done), 32'd0);
        chk("rmwrst_ready", 32'(reqReady), 32'd1);
        step();
        chk("rmwrst_done2", 32'(done), 32'd0);
        do_load("lw30", 3'b010, 32'h30, 32'h1122_3344);

        // Back-to-back stores at one per cycle.
        do_sw("bb0", 32'h0, 32'h0000_000A, 32'd0);
        chk("bb0_ready", 32'(reqReady), 32'd1);
        do_sw("bb4", 32'h4, 32'h0000_000B, 32'd1);
        chk("bb4_ready", 32'(reqReady), 32'd1);
        do_sw("bb8", 32'h8, 32'h0000_000C, 32'd2);
        step();
        chk("bb_done_end", 32'(done), 32'd0);
        do_load("lw4", 3'b010, 32'h4, 32'h0000_000B);
        do_load("lw8", 3'b010, 32'h8, 32'h0000_000C);

        // Address bits above the RAM range are ignored.
        do_load("wrap", 3'b010, 32'h0001_0010, w10_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
